// File: rtl/dw_conv_line_buffer_if.sv
// Stream interface between a raster pixel source and dw_conv_line_buffer.
//   data_in   : one pixel position, all channels packed (channel j at [j*DATA_WIDTH +: DATA_WIDTH])
//   valid_in  : data_in accepted this cycle (no backpressure)
//   data_out  : 3-row column per channel (channel j, slot k at [(j*3+k)*DATA_WIDTH +: DATA_WIDTH])
//   valid_out : data_out holds a valid column
//   sol_out   : column 0 of its row
//   eol_out   : last column of its row
//   eof_out   : last pixel of the frame
// master = pixel source / column sink, slave = line buffer.
interface dw_conv_line_buffer_if #(
    parameter int unsigned CH_NUM     = 18,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [CH_NUM*DATA_WIDTH-1:0]   data_in;
    logic                           valid_in;
    logic [CH_NUM*3*DATA_WIDTH-1:0] data_out;
    logic                           valid_out;
    logic                           sol_out;
    logic                           eol_out;
    logic                           eof_out;

    modport master (
        output data_in, valid_in,
        input  data_out, valid_out, sol_out, eol_out, eof_out
    );

    modport slave (
        input  data_in, valid_in,
        output data_out, valid_out, sol_out, eol_out, eof_out
    );
endinterface

// File: rtl/dw_conv_line_buffer.sv
// Row-buffering column feeder for a depthwise 3x3 window generator.
// Stores the two previous image rows and, for every accepted pixel at (r, c), emits the
// vertical column {row r-2, row r-1, row r} per channel one cycle later. Columns are only
// flagged valid from row 2 onward (valid convolution, no padding).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : dw_conv_line_buffer_if slave (pixel stream in, column stream + row/frame flags out)
module dw_conv_line_buffer #(
    parameter int unsigned CH_NUM     = 18,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32
) (
    input logic                  clk,
    input logic                  rst,
    dw_conv_line_buffer_if.slave bus
);
    localparam int unsigned PixW = CH_NUM * DATA_WIDTH;
    localparam int unsigned ColW = CH_NUM * 3 * DATA_WIDTH;
    localparam int unsigned CW   = $clog2(IMG_WIDTH);
    localparam int unsigned RW   = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] ColLast = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] RowTwo  = RW'(2);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // lb1 holds row r-1, lb2 holds row r-2; no reset, warm-up gating hides stale data.
    logic [PixW-1:0] lb1 [IMG_WIDTH];
    logic [PixW-1:0] lb2 [IMG_WIDTH];
    logic [PixW-1:0] lb1_rd, lb2_rd;

    logic [ColW-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            sol_q, sol_d;
    logic            eol_q, eol_d;
    logic            eof_q, eof_d;

    logic col_end, row_end, row_ge2;

    assign lb1_rd = lb1[col_q];
    assign lb2_rd = lb2[col_q];

    assign col_end = (col_q == ColLast);
    assign row_end = (row_q == RowLast);
    assign row_ge2 = (row_q >= RowTwo);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sol_d   = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;
        if (bus.valid_in) begin
            // Column assembled from pre-write line buffer contents.
            for (int unsigned j = 0; j < CH_NUM; j++) begin
                data_d[(j*3+0)*DATA_WIDTH +: DATA_WIDTH] = lb2_rd[j*DATA_WIDTH +: DATA_WIDTH];
                data_d[(j*3+1)*DATA_WIDTH +: DATA_WIDTH] = lb1_rd[j*DATA_WIDTH +: DATA_WIDTH];
                data_d[(j*3+2)*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[j*DATA_WIDTH +: DATA_WIDTH];
            end
            valid_d = row_ge2;
            sol_d   = row_ge2 && (col_q == '0);
            eol_d   = row_ge2 && col_end;
            eof_d   = row_end && col_end;
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sol_q   <= sol_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            lb2[col_q] <= lb1_rd;
            lb1[col_q] <= bus.data_in;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.sol_out   = sol_q;
    assign bus.eol_out   = eol_q;
    assign bus.eof_out   = eof_q;
endmodule

// File: tb/tb_dw_conv_line_buffer.sv
// Bench for dw_conv_line_buffer: a small 2ch 4x4 instance with directed ramp frames and a
// default 18ch 32x32 instance with random pixels, both checked against a frame-image model.
module tb_dw_conv_line_buffer;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 32;
    localparam int LH = 32;
    localparam int LCH = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dw_conv_line_buffer_if #(.CH_NUM(2), .DATA_WIDTH(8)) bus_s ();
    dw_conv_line_buffer_if #(.CH_NUM(LCH), .DATA_WIDTH(8)) bus_l ();

    dw_conv_line_buffer #(.CH_NUM(2), .DATA_WIDTH(8), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) u_small (
        .clk(clk), .rst(rst), .bus(bus_s)
    );
    dw_conv_line_buffer #(.CH_NUM(LCH), .DATA_WIDTH(8), .IMG_WIDTH(LW), .IMG_HEIGHT(LH)) u_large (
        .clk(clk), .rst(rst), .bus(bus_l)
    );

    int checks = 0;
    int failures = 0;

    // Model state: image of the frame in progress and position in raster order.
    logic [15:0]  img_s [SH][SW];
    logic [143:0] img_l [LH][LW];
    int           idx_s = 0, idx_l = 0;
    logic [47:0]  exp_data_s = '0;
    logic [431:0] exp_data_l = '0;
    bit           known_s = 1, known_l = 1;
    int           nvalid_s, nvalid_l;

    task automatic chk(input string tag, input logic [431:0] obs, input logic [431:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pack_s(input logic [15:0] t, input logic [15:0] m,
                                           input logic [15:0] b);
        logic [47:0] res;
        for (int j = 0; j < 2; j++) begin
            res[(j*3+0)*8 +: 8] = t[j*8 +: 8];
            res[(j*3+1)*8 +: 8] = m[j*8 +: 8];
            res[(j*3+2)*8 +: 8] = b[j*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [431:0] pack_l(input logic [143:0] t, input logic [143:0] m,
                                            input logic [143:0] b);
        logic [431:0] res;
        for (int j = 0; j < LCH; j++) begin
            res[(j*3+0)*8 +: 8] = t[j*8 +: 8];
            res[(j*3+1)*8 +: 8] = m[j*8 +: 8];
            res[(j*3+2)*8 +: 8] = b[j*8 +: 8];
        end
        return res;
    endfunction

    task automatic step_s(input bit v, input logic [15:0] px);
        int r, c;
        bit ev, es, ee, ef;
        ev = 0; es = 0; ee = 0; ef = 0;
        @(negedge clk);
        bus_s.valid_in = v;
        bus_s.data_in  = v ? px : 16'($urandom);
        if (v) begin
            r = idx_s / SW;
            c = idx_s % SW;
            img_s[r][c] = px;
            ev = (r >= 2);
            es = ev && (c == 0);
            ee = ev && (c == SW - 1);
            ef = (r == SH - 1) && (c == SW - 1);
            known_s = ev;
            if (ev) exp_data_s = pack_s(img_s[r-2][c], img_s[r-1][c], px);
            idx_s = (idx_s + 1) % (SW * SH);
        end
        @(posedge clk);
        #1;
        chk("s_valid", 432'(bus_s.valid_out), 432'(ev));
        chk("s_sol", 432'(bus_s.sol_out), 432'(es));
        chk("s_eol", 432'(bus_s.eol_out), 432'(ee));
        chk("s_eof", 432'(bus_s.eof_out), 432'(ef));
        if (known_s) chk("s_data", 432'(bus_s.data_out), 432'(exp_data_s));
        if (bus_s.valid_out) nvalid_s++;
    endtask

    task automatic step_l(input bit v, input logic [143:0] px);
        int r, c;
        bit ev, es, ee, ef;
        ev = 0; es = 0; ee = 0; ef = 0;
        @(negedge clk);
        bus_l.valid_in = v;
        bus_l.data_in  = px;
        if (v) begin
            r = idx_l / LW;
            c = idx_l % LW;
            img_l[r][c] = px;
            ev = (r >= 2);
            es = ev && (c == 0);
            ee = ev && (c == LW - 1);
            ef = (r == LH - 1) && (c == LW - 1);
            known_l = ev;
            if (ev) exp_data_l = pack_l(img_l[r-2][c], img_l[r-1][c], px);
            idx_l = (idx_l + 1) % (LW * LH);
        end
        @(posedge clk);
        #1;
        chk("l_valid", 432'(bus_l.valid_out), 432'(ev));
        chk("l_sol", 432'(bus_l.sol_out), 432'(es));
        chk("l_eol", 432'(bus_l.eol_out), 432'(ee));
        chk("l_eof", 432'(bus_l.eof_out), 432'(ef));
        if (known_l) chk("l_data", bus_l.data_out, exp_data_l);
        if (bus_l.valid_out) nvalid_l++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_s_valid"}, 432'(bus_s.valid_out), '0);
        chk({tag, "_s_flags"}, 432'({bus_s.sol_out, bus_s.eol_out, bus_s.eof_out}), '0);
        chk({tag, "_s_data"}, 432'(bus_s.data_out), '0);
        chk({tag, "_l_valid"}, 432'(bus_l.valid_out), '0);
        chk({tag, "_l_flags"}, 432'({bus_l.sol_out, bus_l.eol_out, bus_l.eof_out}), '0);
        chk({tag, "_l_data"}, bus_l.data_out, '0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        bus_s.valid_in = 1'b0;
        bus_l.valid_in = 1'b0;
        #1;
        check_zero({tag, "_async"});
        @(posedge clk);
        #1;
        check_zero({tag, "_hold"});
        @(negedge clk);
        rst = 1'b0;
        idx_s = 0; idx_l = 0;
        exp_data_s = '0; exp_data_l = '0;
        known_s = 1; known_l = 1;
    endtask

    // One 4x4 ramp frame: pixel(ch,r,c) = ch*64 + r*16 + c + off.
    task automatic run_ramp_s(input bit bubbles, input logic [7:0] off, input string tag);
        logic [7:0] p0, p1;
        nvalid_s = 0;
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                p0 = 8'(r * 16 + c) + off;
                p1 = 8'(64 + r * 16 + c) + off;
                step_s(1'b1, {p1, p0});
                if (r == 2 && c == 1 && off == 8'h00)
                    chk({tag, "_col21"}, 432'(bus_s.data_out), 432'(48'h615141_211101));
                if (r == 2 && c == 0 && off == 8'h80)
                    chk({tag, "_first"}, 432'(bus_s.data_out), 432'(48'hE0D0C0_A09080));
                if (bubbles) begin
                    step_s(1'b0, '0);
                    if (c == SW - 1) for (int k = 0; k < 4; k++) step_s(1'b0, '0);
                end
            end
        end
        chk({tag, "_nvalid"}, 432'(nvalid_s), 432'(8));
    endtask

    initial begin
        logic [143:0] px;
        bus_s.valid_in = 1'b0;
        bus_s.data_in  = '0;
        bus_l.valid_in = 1'b0;
        bus_l.data_in  = '0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("por");
        @(negedge clk);
        rst = 1'b0;

        run_ramp_s(1'b0, 8'h00, "ramp");
        run_ramp_s(1'b0, 8'h80, "b2b");
        run_ramp_s(1'b1, 8'h00, "bubble");

        for (int i = 0; i < 10; i++) step_s(1'b1, 16'($urandom));
        do_reset("midrst");
        run_ramp_s(1'b0, 8'h00, "postrst");

        for (int f = 0; f < 2; f++) begin
            nvalid_l = 0;
            for (int n = 0; n < LW * LH; n++) begin
                px = {$urandom, $urandom, $urandom, $urandom, $urandom};
                step_l(1'b1, px);
                if ($urandom_range(0, 3) == 0) step_l(1'b0, {$urandom, $urandom, 80'h0});
            end
            chk("large_nvalid", 432'(nvalid_l), 432'((LH - 2) * LW));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
